pwm_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM controller: register word indices, bit positions, field width.
// No logic; constants only.
// No flow control.
package pwm_pkg;

  // Default width of the prescaler, period and duty fields
  localparam int CW_DEFAULT = 16;

  // Register word indices (byte address bits [4:2])
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PRESC  = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_DUTY0  = 3'd4;

  // CTRL bit positions; force_update is a write-only pulse
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FORCE_BIT  = 2;

  // STATUS bit positions
  localparam int STATUS_DONE_BIT = 0;

endpackage

// File: rtl/pwm_prescaler.sv
// Programmable prescaler: one-cycle tick every presc+1 enabled cycles.
// tick is combinational from the count register, same cycle as pcnt==presc.
// No backpressure; counter is held at 0 while en is low.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          en,
  input  logic [CW-1:0] presc,
  output logic          tick
);

  logic [CW-1:0] pcnt_q;
  logic [CW-1:0] pcnt_d;

  // Tick on the terminal count; >= also recovers if presc is lowered below the running count
  always_comb begin
    tick   = en & (pcnt_q >= presc);
    pcnt_d = pcnt_q + CW'(1);
    if (!en || tick) begin
      pcnt_d = '0;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_ctrl.sv
// Wishbone PWM controller: shadowed prescaler/period/duty registers, shared period counter, NCH outputs.
// Bus: ack one cycle after request, no wait states; pwm_o registered one cycle after the counter.
// No backpressure; every access is acked once, ack drops the following cycle.
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEFAULT
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  input  logic [2:0]     wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  output logic           wb_ack_o,
  output logic [NCH-1:0] pwm_o,
  output logic           irq_o
);

  // Bus state
  logic          ack_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata;

  // Control and status
  logic          en_q;
  logic          en_d;
  logic          irq_en_q;
  logic          done_q;
  logic          irq_q;

  // Shadow (software-visible) and active (in use) timing registers
  logic [CW-1:0] presc_s_q;
  logic [CW-1:0] presc_a_q;
  logic [CW-1:0] period_s_q;
  logic [CW-1:0] period_a_q;
  logic [CW-1:0] duty_s_q [NCH];
  logic [CW-1:0] duty_a_q [NCH];

  // Period counter and outputs
  logic [CW-1:0]  cnt_q;
  logic [NCH-1:0] pwm_q;
  logic [NCH-1:0] pwm_d;

  logic req;
  logic wr;
  logic rd;
  logic wr_ctrl;
  logic wr_status;
  logic en_rise;
  logic force_upd;
  logic tick;
  logic wrap;
  logic commit;

  // Upper write-data bits beyond the field width are not stored
  logic unused_dat;
  assign unused_dat = ^wb_dat_i[31:CW];

  // A request is accepted in the cycle before its ack, so writes land on the ack edge
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = req & wb_we_i;
  assign rd        = req & ~wb_we_i;
  assign wr_ctrl   = wr && (wb_adr_i == REG_CTRL);
  assign wr_status = wr && (wb_adr_i == REG_STATUS);
  assign en_d      = wr_ctrl ? wb_dat_i[CTRL_EN_BIT] : en_q;
  assign en_rise   = en_d & ~en_q;
  assign force_upd = wr_ctrl & wb_dat_i[CTRL_FORCE_BIT];

  pwm_prescaler #(.CW(CW)) u_presc (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (en_q),
    .presc  (presc_a_q),
    .tick   (tick)
  );

  // Last tick of the period; >= guards against a forced period shorter than the current count
  assign wrap   = en_q & tick & (cnt_q >= period_a_q);
  assign commit = wrap | en_rise | force_upd;

  // Register file: software writes hit shadows, actives reload only at safe points
  always_ff @(posedge clk_in) begin
    if (reset) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      presc_s_q  <= '0;
      presc_a_q  <= '0;
      period_s_q <= '0;
      period_a_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_s_q[i] <= '0;
        duty_a_q[i] <= '0;
      end
    end else begin
      en_q <= en_d;
      if (wr_ctrl) begin
        irq_en_q <= wb_dat_i[CTRL_IRQ_EN_BIT];
      end
      if (wr && wb_adr_i == REG_PRESC) begin
        presc_s_q <= wb_dat_i[CW-1:0];
      end
      if (wr && wb_adr_i == REG_PERIOD) begin
        period_s_q <= wb_dat_i[CW-1:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr && wb_adr_i == REG_DUTY0 + 3'(i)) begin
          duty_s_q[i] <= wb_dat_i[CW-1:0];
        end
      end
      if (commit) begin
        presc_a_q  <= presc_s_q;
        period_a_q <= period_s_q;
        for (int i = 0; i < NCH; i++) begin
          duty_a_q[i] <= duty_s_q[i];
        end
      end
    end
  end

  // Sticky done flag; a wrap on the same edge as a clear wins
  always_ff @(posedge clk_in) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (wrap) begin
      done_q <= 1'b1;
    end else if (wr_status && wb_dat_i[STATUS_DONE_BIT]) begin
      done_q <= 1'b0;
    end
  end

  // Period counter advances on prescaler ticks, parked at 0 while disabled
  always_ff @(posedge clk_in) begin
    if (reset || !en_q) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Compare each active duty against the shared count
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = en_q & (cnt_q < duty_a_q[i]);
    end
  end

  // Registered outputs and interrupt
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pwm_q <= '0;
      irq_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      irq_q <= done_q & irq_en_q;
    end
  end

  // Read mux: shadows are read back so software sees what it wrote
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]     = en_q;
        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      REG_PRESC:  rdata = 32'(presc_s_q);
      REG_PERIOD: rdata = 32'(period_s_q);
      REG_STATUS: rdata[STATUS_DONE_BIT] = done_q;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (wb_adr_i == REG_DUTY0 + 3'(i)) begin
            rdata = 32'(duty_s_q[i]);
          end
        end
      end
    endcase
  end

  // Single-cycle ack; read data presented only alongside a read ack
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
      dat_q <= rd ? rdata : 32'd0;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign pwm_o    = pwm_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: directed bus sequences plus randomized configurations.
// Expected PWM waveform derived arithmetically from prescaler/period/duty settings.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pwm_ctrl;

  localparam int NCH = 4;
  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRESC  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;

  typedef int duty_arr_t [4];

  logic           clk_in   = 1'b0;
  logic           reset    = 1'b1;
  logic           wb_cyc_i = 1'b0;
  logic           wb_stb_i = 1'b0;
  logic           wb_we_i  = 1'b0;
  logic [2:0]     wb_adr_i = 3'd0;
  logic [31:0]    wb_dat_i = 32'd0;
  logic [31:0]    wb_dat_o;
  logic           wb_ack_o;
  logic [NCH-1:0] pwm_o;
  logic           irq_o;

  always #5 clk_in = ~clk_in;

  pwm_ctrl #(.NCH(NCH), .CW(16)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .pwm_o    (pwm_o),
    .irq_o    (irq_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;
  bit chk_pwm = 0;
  bit chk_irq = 0;

  // Reference configuration of the current run
  int m_p;
  int m_n;
  int m_len;
  bit m_irqen;
  int        sw_t [$];
  duty_arr_t sw_d [$];

  // Output in cycle tt (tt=0 is the cycle right after enable): counter value of the previous cycle vs duty in force
  function automatic logic [3:0] exp_pwm(int tt);
    logic [3:0] r;
    int idx;
    duty_arr_t d;
    r = '0;
    if (tt < 1) return r;
    idx = ((tt - 1) / (m_p + 1)) % (m_n + 1);
    d = sw_d[0];
    for (int k = 0; k < sw_t.size(); k++) begin
      if (sw_t[k] <= tt) d = sw_d[k];
    end
    for (int i = 0; i < 4; i++) r[i] = (idx < d[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    t++;
    if (chk_pwm) chk("pwm", 32'(pwm_o), 32'(exp_pwm(t)));
    if (chk_irq) chk("irq", 32'(irq_o), (m_irqen && t >= m_len + 1) ? 32'd1 : 32'd0);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
    step();
    chk("wr_ack", 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    step();
    chk("rd_ack", 32'(wb_ack_o), 32'd1);
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  // Disable, clear done, program shadows, then enable (which loads them); t=0 afterwards
  task automatic start_run(input int p, input int n, input duty_arr_t d, input bit irqen);
    chk_pwm = 0;
    chk_irq = 0;
    wb_write(A_CTRL, 32'd0);
    wb_write(A_STATUS, 32'd1);
    wb_write(A_PRESC, 32'(p));
    wb_write(A_PERIOD, 32'(n));
    for (int i = 0; i < 4; i++) wb_write(3'(4 + i), 32'(d[i]));
    m_p = p; m_n = n; m_len = (p + 1) * (n + 1); m_irqen = irqen;
    sw_t.delete(); sw_d.delete();
    sw_t.push_back(0); sw_d.push_back(d);
    wb_write(A_CTRL, irqen ? 32'd3 : 32'd1);
    t = 0;
  endtask

  task automatic run_trial(input int p, input int n, input duty_arr_t d, input bit irqen);
    logic [31:0] rd;
    start_run(p, n, d, irqen);
    chk_pwm = 1;
    chk_irq = 1;
    repeat (2 * m_len + 2) step();
    chk_pwm = 0;
    chk_irq = 0;
    wb_read(A_STATUS, rd);
    chk("done_set", rd, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    duty_arr_t d;
    int p, n;

    // Reset state
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), rd);
      chk("rst_reg", rd, 32'd0);
    end

    // Fast PWM, zero duty, duty above period, no interrupt
    d = '{3, 0, 9, 32'hFFFF};
    run_trial(0, 9, d, 1'b0);
    wb_read(A_PERIOD, rd); chk("period_rd", rd, 32'd9);
    wb_read(A_CTRL, rd);   chk("ctrl_rd1", rd, 32'd1);
    wb_read(3'd7, rd);     chk("duty3_rd", rd, 32'hFFFF);
    wb_write(A_CTRL, 32'd0);
    step();
    chk("dis_pwm", 32'(pwm_o), 32'd0);
    repeat (3) step();
    chk("dis_pwm2", 32'(pwm_o), 32'd0);

    // Prescaled PWM with interrupt
    d = '{1, 5, 0, 10};
    run_trial(4, 9, d, 1'b1);

    // Randomized configurations
    repeat (5) begin
      p = $urandom_range(0, 3);
      n = $urandom_range(0, 12);
      for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, n + 2);
      run_trial(p, n, d, 1'($urandom_range(0, 1)));
    end

    // Shadowing, done clear races, force update, reset mid-period
    d = '{3, 8, 8, 8};
    start_run(0, 9, d, 1'b1);
    chk_pwm = 1;
    d = '{7, 8, 8, 8};
    sw_t.push_back(11); sw_d.push_back(d);
    while (t < 1) step();
    wb_write(3'd4, 32'd7);
    while (t < 8) step();
    wb_write(A_STATUS, 32'd1);
    wb_read(A_STATUS, rd);
    chk("done_w1c_wrap", rd, 32'd1);
    wb_write(A_STATUS, 32'd1);
    chk("irq_hold", 32'(irq_o), 32'd1);
    step();
    chk("irq_drop", 32'(irq_o), 32'd0);
    wb_read(A_STATUS, rd);
    chk("done_w1c", rd, 32'd0);
    while (t < 30) step();
    d = '{1, 8, 8, 8};
    sw_t.push_back(35); sw_d.push_back(d);
    wb_write(3'd4, 32'd1);
    wb_write(A_CTRL, 32'd7);
    wb_read(A_CTRL, rd);
    chk("ctrl_rd_force", rd, 32'd3);
    while (t < 45) step();
    chk("irq_pre_rst", 32'(irq_o), 32'd1);
    chk_pwm = 0;
    reset = 1'b1;
    step();
    chk("mrst_pwm", 32'(pwm_o), 32'd0);
    chk("mrst_irq", 32'(irq_o), 32'd0);
    chk("mrst_ack", 32'(wb_ack_o), 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), rd);
      chk("mrst_reg", rd, 32'd0);
    end
    repeat (3) step();
    chk("mrst_pwm_idle", 32'(pwm_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
